// File: rtl/timer_pkg.sv
// Shared definitions for the bridge-attached down-counting timer:
// FSM states, register addresses, CTRL field positions and mode encodings.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int unsigned CTRL_W   = 32'd4;
   localparam int unsigned EN_BIT   = 32'd0;
   localparam int unsigned MODE_LSB = 32'd1;
   localparam int unsigned IM_BIT   = 32'd3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/hw_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Register file, FSM and counter share one module because bus writes override FSM updates.
module hw_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   timer_state_e          state_r;
   timer_state_e          state_s;
   timer_state_e          fsm_state_s;
   logic [CTRL_W-1:0]     ctrl_r;
   logic [CTRL_W-1:0]     ctrl_s;
   logic [CTRL_W-1:0]     fsm_ctrl_s;
   logic [WIDTH-1:0]      preset_r;
   logic [WIDTH-1:0]      preset_s;
   logic [WIDTH-1:0]      count_r;
   logic [WIDTH-1:0]      count_s;
   logic [WIDTH-1:0]      fsm_count_s;
   logic                  irq_pend_r;
   logic                  irq_pend_s;
   logic                  fsm_pend_s;
   logic                  ctrl_wr_s;
   logic                  preset_wr_s;
   logic                  stop_s;

   assign ctrl_wr_s   = we && (addr == ADDR_CTRL);
   assign preset_wr_s = we && (addr == ADDR_PRESET);
   assign stop_s      = ctrl_wr_s && !wdata[EN_BIT];

   // FSM next state and counter update, before bus writes are applied
   always_comb begin
      fsm_state_s = state_r;
      fsm_count_s = count_r;
      fsm_ctrl_s  = ctrl_r;
      fsm_pend_s  = irq_pend_r;
      case (state_r)
         IDLE: begin
            fsm_state_s = ctrl_r[EN_BIT] ? LOAD : IDLE;
         end
         LOAD: begin
            fsm_count_s = preset_r;
            fsm_state_s = CNT;
         end
         CNT: begin
            if (!ctrl_r[EN_BIT]) begin
               fsm_state_s = IDLE;
            end else if (count_r <= WIDTH'(1)) begin
               // Saturate at zero so PRESET=0 terminates instead of wrapping.
               fsm_count_s = '0;
               fsm_pend_s  = 1'b1;
               fsm_state_s = INT;
            end else begin
               fsm_count_s = count_r - WIDTH'(1);
            end
         end
         INT: begin
            if (ctrl_r[MODE_LSB +: 2] == MODE_RELOAD) begin
               fsm_pend_s  = 1'b0;
               fsm_state_s = LOAD;
            end else begin
               fsm_ctrl_s[EN_BIT] = 1'b0;
               fsm_state_s        = IDLE;
            end
         end
         default: begin
            fsm_state_s = IDLE;
         end
      endcase
   end

   // A software write on the same edge as an FSM event wins.
   assign state_s    = stop_s ? IDLE : fsm_state_s;
   assign count_s    = stop_s ? count_r : fsm_count_s;
   assign ctrl_s     = ctrl_wr_s ? wdata[CTRL_W-1:0] : fsm_ctrl_s;
   assign preset_s   = preset_wr_s ? wdata[WIDTH-1:0] : preset_r;
   assign irq_pend_s = (ctrl_wr_s || preset_wr_s) ? 1'b0 : fsm_pend_s;

   // State, register file and counter flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ctrl_r     <= '0;
         preset_r   <= '0;
         count_r    <= '0;
         irq_pend_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         ctrl_r     <= ctrl_s;
         preset_r   <= preset_s;
         count_r    <= count_s;
         irq_pend_r <= irq_pend_s;
      end
   end

   // Read mux, zero-extending narrower fields to the 32-bit bus
   always_comb begin
      rdata = 32'd0;
      case (addr)
         ADDR_CTRL:   rdata[CTRL_W-1:0] = ctrl_r;
         ADDR_PRESET: rdata[WIDTH-1:0]  = preset_r;
         ADDR_COUNT:  rdata[WIDTH-1:0]  = count_r;
         default:     rdata             = 32'd0;
      endcase
   end

   assign irq = irq_pend_r & ctrl_r[IM_BIT];

endmodule

// File: tb/tb_hw_timer.sv
// Self-checking bench for hw_timer: directed scenarios plus randomized one-shot and
// auto-reload runs checked against closed-form expectations in edge count k after the start write.
module tb_hw_timer;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  addr  = 2'd0;
   logic        we    = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;

   int          n_cmp   = 0;
   int          n_bad   = 0;
   logic [31:0] exp_cnt = 32'd0;

   hw_timer #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // One-shot: LOAD at k=2, then one decrement per edge down to 0.
   function automatic logic [31:0] os_count(input int p, input int k, input logic [31:0] prev);
      if (k < 2) return prev;
      if (k - 2 >= p) return 32'd0;
      return 32'(p - (k - 2));
   endfunction

   function automatic bit os_pend(input int p, input int k);
      return k >= 2 + ((p < 1) ? 1 : p);
   endfunction

   function automatic bit os_en(input int p, input int k);
      return k < 3 + ((p < 1) ? 1 : p);
   endfunction

   // Auto-reload: period p+2 starting at the first LOAD (k=2).
   function automatic logic [31:0] rl_count(input int p, input int k, input logic [31:0] prev);
      int j;
      if (k < 2) return prev;
      j = (k - 2) % (p + 2);
      return (j <= p) ? 32'(p - j) : 32'd0;
   endfunction

   function automatic bit rl_irq(input int p, input int k);
      return (k >= 2) && (((k - 2) % (p + 2)) == p);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic step(input bit do_we, input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = do_we;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic run_os(input int p, input bit im, input logic [1:0] mode, input int ncyc);
      logic [31:0] prev;
      logic [31:0] d;
      prev = exp_cnt;
      step(1'b1, 2'd1, 32'(p));
      step(1'b1, 2'd0, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= ncyc; k++) begin
         step(1'b0, 2'd3, 32'd0);
         check("os_irq", {31'd0, irq}, {31'd0, os_pend(p, k) & im});
         rd(2'd2, d);
         check("os_count", d, os_count(p, k, prev));
         rd(2'd0, d);
         check("os_ctrl", d, {28'd0, im, mode, os_en(p, k)});
      end
      exp_cnt = os_count(p, ncyc, prev);
   endtask

   task automatic run_rl(input int p, input int ncyc);
      logic [31:0] prev;
      logic [31:0] d;
      bit          last_irq;
      prev     = exp_cnt;
      last_irq = 1'b0;
      step(1'b1, 2'd1, 32'(p));
      step(1'b1, 2'd0, 32'hB);
      for (int k = 1; k <= ncyc; k++) begin
         step(1'b0, 2'd3, 32'd0);
         check("rl_irq", {31'd0, irq}, {31'd0, rl_irq(p, k)});
         check("rl_no_double", {31'd0, irq & last_irq}, 32'd0);
         last_irq = irq;
         rd(2'd2, d);
         check("rl_count", d, rl_count(p, k, prev));
      end
      exp_cnt = rl_count(p, ncyc, prev);
      step(1'b1, 2'd0, 32'd0);
      rd(2'd2, d);
      check("rl_stop_count", d, exp_cnt);
      check("rl_stop_irq", {31'd0, irq}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          p;
      bit          im;
      logic [1:0]  mode;

      // Power-up reset
      #3;
      check("rst_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, d); check("rst_ctrl", d, 32'd0);
      rd(2'd1, d); check("rst_preset", d, 32'd0);
      rd(2'd2, d); check("rst_count", d, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed one-shot, PRESET=3, IM=1; irq held until a CTRL write
      run_os(3, 1'b1, 2'b00, 8);
      step(1'b1, 2'd0, 32'h8);
      check("os_clear_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, d); check("os_clear_ctrl", d, 32'h8);

      // PRESET=0 terminates on the first CNT edge without wrapping
      run_os(0, 1'b1, 2'b00, 5);

      // Asynchronous reset mid-count at COUNT=5
      run_os(8, 1'b1, 2'b00, 5);
      #1 rst_n = 1'b0;
      #1 check("amid_irq", {31'd0, irq}, 32'd0);
      rd(2'd2, d); check("amid_count", d, 32'd0);
      rd(2'd0, d); check("amid_ctrl", d, 32'd0);
      rd(2'd1, d); check("amid_preset", d, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      exp_cnt = 32'd0;

      // Randomized one-shot runs (modes 00/10/11, random IM); COUNT writes ignored
      repeat (6) begin
         p    = $urandom_range(0, 6);
         im   = 1'($urandom_range(0, 1));
         mode = 2'($urandom_range(0, 2));
         if (mode == 2'd1) mode = 2'd3;
         run_os(p, im, mode, p + 5);
         step(1'b1, 2'd2, $urandom);
         rd(2'd2, d); check("count_ro", d, exp_cnt);
         rd(2'd3, d); check("addr3_zero", d, 32'd0);
         step(1'b1, 2'd0, 32'd0);
      end

      // Randomized auto-reload runs, three periods each
      repeat (3) begin
         p = $urandom_range(1, 6);
         run_rl(p, 2 + 3 * (p + 2) + $urandom_range(0, 3));
      end

      // PRESET rewritten mid-count: current run ends from 8, next LOAD uses 10
      step(1'b1, 2'd1, 32'd8);
      step(1'b1, 2'd0, 32'hB);
      for (int k = 1; k <= 14; k++) begin
         step((k == 5), 2'd1, 32'd10);
         rd(2'd2, d);
         check("pw_count", d, (k < 2) ? exp_cnt : (k < 12) ? rl_count(8, k, exp_cnt) : 32'(10 - (k - 12)));
         check("pw_irq", {31'd0, irq}, {31'd0, (k == 10)});
      end
      step(1'b1, 2'd0, 32'd0);
      rd(2'd2, d);
      exp_cnt = d;
      check("pw_stop_count", d, 32'd8);

      // CTRL write on the terminal-count edge clears irq_pend
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
         step((k == 4), 2'd0, 32'h9);
         check("tc_irq", {31'd0, irq}, 32'd0);
      end
      rd(2'd0, d); check("tc_ctrl_hwclr", d, 32'h8);

      // CTRL write on the INT edge discards the hardware EN-clear
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         step((k == 5), 2'd0, 32'h9);
         if (k == 4) check("int_irq_set", {31'd0, irq}, 32'd1);
         if (k == 5) begin
            check("int_irq_clr", {31'd0, irq}, 32'd0);
            rd(2'd0, d); check("int_ctrl_kept", d, 32'h9);
         end
      end
      rd(2'd2, d); check("int_restart_count", d, 32'd2);
      step(1'b1, 2'd0, 32'd0);
      exp_cnt = 32'd2;

      // IM=0 masks irq while the one-shot still terminates and clears EN
      run_os(1, 1'b0, 2'b00, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
